axi_txn_arbiter: RTL and testbench

//  Shares one custom AXI master (INIT_AXI_TXN / TXN_DONE / ERROR interface) among NUM_REQ requesters.

---
 rtl/axi_txn_arbiter.sv | 124 ++++++++++++
 tb/tb_axi_txn_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_txn_arbiter.sv
// Round-robin arbiter sharing one AXI master (init/done/error handshake) among NUM_REQ requesters.
// Tracks completed transactions and timeouts; all outputs are registered.
module axi_txn_arbiter #(
  parameter int NUM_REQ           = 4,
  parameter int INIT_PULSE_CYCLES = 2,
  parameter int TIMEOUT_CYCLES    = 4096
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic [NUM_REQ-1:0] REQ,
  output logic [NUM_REQ-1:0] GRANT,
  output logic [NUM_REQ-1:0] REQ_DONE,
  output logic [NUM_REQ-1:0] REQ_ERROR,
  output logic               M_INIT_AXI_TXN,
  input  logic               M_TXN_DONE,
  input  logic               M_ERROR,
  output logic               BUSY,
  output logic [15:0]        TXN_CNT,
  output logic [7:0]         TIMEOUT_CNT
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W  = $clog2(TIMEOUT_CYCLES);
  localparam int INIT_W = (INIT_PULSE_CYCLES > 1) ? $clog2(INIT_PULSE_CYCLES) : 1;

  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_PULSE_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_MAX   = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, INIT, WAIT, RESP} state_t;

  state_t              state;
  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    owner;
  logic [IDX_W-1:0]    pick_idx;
  logic [IDX_W-1:0]    cand;
  logic                pick_valid;
  logic                done_q;
  logic                done_edge;
  logic [TMR_W-1:0]    timer;
  logic [INIT_W-1:0]   init_cnt;

  // The master holds done as a level until the next init, so only a fresh rise completes a txn.
  assign done_edge = M_TXN_DONE & ~done_q;

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!pick_valid && REQ[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state          <= IDLE;
      ptr            <= '0;
      owner          <= '0;
      done_q         <= 1'b0;
      timer          <= '0;
      init_cnt       <= '0;
      GRANT          <= '0;
      REQ_DONE       <= '0;
      REQ_ERROR      <= '0;
      M_INIT_AXI_TXN <= 1'b0;
      BUSY           <= 1'b0;
      TXN_CNT        <= '0;
      TIMEOUT_CNT    <= '0;
    end else begin
      done_q <= M_TXN_DONE;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state          <= INIT;
            owner          <= pick_idx;
            GRANT          <= NUM_REQ'(1) << pick_idx;
            M_INIT_AXI_TXN <= 1'b1;
            BUSY           <= 1'b1;
            init_cnt       <= INIT_LAST;
          end
        end
        INIT: begin
          if (init_cnt == '0) begin
            M_INIT_AXI_TXN <= 1'b0;
            state          <= WAIT;
            timer          <= '0;
          end else begin
            init_cnt <= init_cnt - 1'b1;
          end
        end
        WAIT: begin
          timer <= timer + 1'b1;
          // A completion landing on the final timeout cycle still counts as a real completion.
          if (done_edge) begin
            state     <= RESP;
            REQ_DONE  <= GRANT;
            REQ_ERROR <= M_ERROR ? GRANT : '0;
          end else if (timer == TMR_LAST) begin
            state     <= RESP;
            REQ_DONE  <= GRANT;
            REQ_ERROR <= GRANT;
            if (TIMEOUT_CNT != 8'hFF) TIMEOUT_CNT <= TIMEOUT_CNT + 1'b1;
          end
        end
        RESP: begin
          state     <= IDLE;
          GRANT     <= '0;
          REQ_DONE  <= '0;
          REQ_ERROR <= '0;
          BUSY      <= 1'b0;
          TXN_CNT   <= TXN_CNT + 1'b1;
          ptr       <= (owner == IDX_MAX) ? '0 : owner + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_txn_arbiter.sv
// Self-checking bench for axi_txn_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level timeline model.
module tb_axi_txn_arbiter;

  localparam int N = 4;
  localparam int P = 2;
  localparam int T = 16;

  logic         ACLK = 1'b0;
  logic         ARESETN = 1'b0;
  logic [N-1:0] REQ = '0;
  logic         M_TXN_DONE = 1'b0;
  logic         M_ERROR = 1'b0;
  logic [N-1:0] GRANT;
  logic [N-1:0] REQ_DONE;
  logic [N-1:0] REQ_ERROR;
  logic         M_INIT_AXI_TXN;
  logic         BUSY;
  logic [15:0]  TXN_CNT;
  logic [7:0]   TIMEOUT_CNT;

  axi_txn_arbiter #(
    .NUM_REQ(N),
    .INIT_PULSE_CYCLES(P),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .ACLK(ACLK),
    .ARESETN(ARESETN),
    .REQ(REQ),
    .GRANT(GRANT),
    .REQ_DONE(REQ_DONE),
    .REQ_ERROR(REQ_ERROR),
    .M_INIT_AXI_TXN(M_INIT_AXI_TXN),
    .M_TXN_DONE(M_TXN_DONE),
    .M_ERROR(M_ERROR),
    .BUSY(BUSY),
    .TXN_CNT(TXN_CNT),
    .TIMEOUT_CNT(TIMEOUT_CNT)
  );

  always #5 ACLK = ~ACLK;

  // Per-transaction master behaviour, offsets relative to the first grant cycle.
  typedef struct {
    int f;
    int e;
    bit resp;
    bit merr;
  } plan_t;

  plan_t        plan_q[$];
  int           grant_log[$];
  logic [N-1:0] prev_grant = '0;

  int   passCount = 0;
  int   checkCount = 0;
  int   cyc = 0;
  bit   cur_valid = 0;
  int   cur_c, cur_r, cur_g, cur_f, cur_e;
  bit   cur_err, cur_to, cur_resp, cur_merr;
  int   ptr_m = 0;
  int   txn_exp = 0;
  int   tmo_exp = 0;
  int   n_start = 0;
  logic [N-1:0] req_v = '0;
  logic done_lvl = 1'b0;
  bit   hold_all = 0;
  bit   rand_mode = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s at cycle %0d: observed 0x%0h, expected 0x%0h", tag, cyc, observed, expected);
  endtask

  function automatic bit model_idle();
    return (!cur_valid || cyc > cur_r) && (req_v == '0);
  endfunction

  task automatic checkAll();
    bit           act;
    logic [N-1:0] oh;
    logic [N-1:0] dn;
    logic [N-1:0] er;
    act = cur_valid && cyc >= cur_c && cyc <= cur_r;
    oh = '0;
    if (act) oh[cur_g] = 1'b1;
    dn = (act && cyc == cur_r) ? oh : '0;
    er = (act && cyc == cur_r && cur_err) ? oh : '0;
    checkOutput("grant", GRANT, oh);
    checkOutput("init", M_INIT_AXI_TXN, act && cyc <= cur_c + P - 1);
    checkOutput("busy", BUSY, act);
    checkOutput("req_done", REQ_DONE, dn);
    checkOutput("req_error", REQ_ERROR, er);
    checkOutput("txn_cnt", TXN_CNT, txn_exp);
    checkOutput("timeout_cnt", TIMEOUT_CNT, tmo_exp);
    if (GRANT != '0 && prev_grant == '0)
      for (int i = 0; i < N; i++) if (GRANT[i]) grant_log.push_back(i);
    prev_grant = GRANT;
  endtask

  task automatic start_txn();
    plan_t p;
    int g;
    g = -1;
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = (ptr_m + i) % N;
      if (g < 0 && req_v[idx]) g = idx;
    end
    if (plan_q.size() > 0) p = plan_q.pop_front();
    else begin
      p.f = 1;
      p.e = $urandom_range(P + T + 6, 2);
      p.resp = ($urandom_range(7) != 0);
      p.merr = ($urandom_range(1) == 1);
    end
    cur_valid = 1; cur_c = cyc + 1; cur_g = g;
    cur_f = p.f; cur_e = p.e; cur_resp = p.resp; cur_merr = p.merr;
    n_start++;
    // Completion only counts if the done rise lands inside the T-cycle wait window.
    if (p.resp && p.e >= P && p.e <= P + T - 1) begin
      cur_r = cur_c + p.e + 1; cur_err = p.merr; cur_to = 0;
    end else begin
      cur_r = cur_c + P + T; cur_err = 1; cur_to = 1;
    end
  endtask

  task automatic applyStimulus();
    if (!hold_all && cur_valid && cyc == cur_r + 1) req_v[cur_g] = 1'b0;
    if (rand_mode) begin
      for (int i = 0; i < N; i++)
        if (!(cur_valid && cyc <= cur_r && i == cur_g) && !req_v[i] && $urandom_range(3) == 0)
          req_v[i] = 1'b1;
      if (cur_valid && cyc >= cur_c && cyc < cur_r && $urandom_range(39) == 0) req_v[cur_g] = 1'b0;
    end
    REQ = req_v;
    if ((!cur_valid || cyc > cur_r) && req_v != '0) start_txn();
    if (cur_valid && cyc == cur_c + cur_f) done_lvl = 1'b0;
    if (cur_valid && cur_resp && cyc == cur_c + cur_e) done_lvl = 1'b1;
    M_TXN_DONE = done_lvl;
    M_ERROR = cur_merr;
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
    cyc++;
    if (cur_valid && cyc == cur_r + 1) begin
      txn_exp = (txn_exp + 1) % 65536;
      ptr_m = (cur_g + 1) % N;
    end
    if (cur_valid && cyc == cur_r && cur_to && tmo_exp < 255) tmo_exp++;
    checkAll();
    applyStimulus();
  endtask

  task automatic run_idle();
    for (int k = 0; k < 400 && !model_idle(); k++) tick();
    tick();
    tick();
  endtask

  task automatic do_reset();
    ARESETN = 1'b0;
    REQ = '0; req_v = '0; done_lvl = 1'b0; M_TXN_DONE = 1'b0; M_ERROR = 1'b0;
    cur_valid = 0; cur_merr = 0; ptr_m = 0; txn_exp = 0; tmo_exp = 0; hold_all = 0;
    plan_q.delete();
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    ARESETN = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", checkCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t2_exp[5] = '{0, 1, 2, 3, 0};

    do_reset();

    // Single request, clean completion ten cycles after the request cycle.
    plan_q.push_back('{1, 9, 1'b1, 1'b0});
    req_v = 4'b0001;
    run_idle();
    checkOutput("t1_txn_cnt", TXN_CNT, 1);
    checkOutput("t1_busy", BUSY, 0);

    // Master reports an error.
    plan_q.push_back('{1, 6, 1'b1, 1'b1});
    req_v = 4'b0100;
    run_idle();
    checkOutput("t3_timeout_cnt", TIMEOUT_CNT, 0);
    checkOutput("t3_txn_cnt", TXN_CNT, 2);

    // All requesters held, fast master: fair rotation.
    do_reset();
    for (int i = 0; i < 5; i++) plan_q.push_back('{1, 3, 1'b1, 1'b0});
    hold_all = 1; req_v = 4'b1111; n_start = 0; grant_log.delete();
    for (int k = 0; k < 200 && n_start < 5; k++) tick();
    req_v = '0; hold_all = 0;
    run_idle();
    checkOutput("t2_grant_count", grant_log.size(), 5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++)
      checkOutput($sformatf("t2_grant%0d", i), grant_log[i], t2_exp[i]);
    checkOutput("t2_txn_cnt", TXN_CNT, 5);

    // Master never answers in time; late done rise five cycles after the timeout response.
    do_reset();
    plan_q.push_back('{1, P + T + 5, 1'b1, 1'b0});
    req_v = 4'b0010;
    tick();
    for (int k = 0; k < 100 && !(cyc >= cur_r + 8); k++) tick();
    checkOutput("t4_timeout_cnt", TIMEOUT_CNT, 1);
    checkOutput("t4_txn_cnt", TXN_CNT, 1);

    // Asynchronous reset in the middle of a wait.
    plan_q.push_back('{1, 2, 1'b0, 1'b0});
    req_v = 4'b0100;
    tick();
    for (int k = 0; k < 50 && !(cyc >= cur_c + P + 3); k++) tick();
    #3;
    ARESETN = 1'b0;
    #1;
    checkOutput("t5_grant", GRANT, 0);
    checkOutput("t5_init", M_INIT_AXI_TXN, 0);
    checkOutput("t5_busy", BUSY, 0);
    checkOutput("t5_req_done", REQ_DONE, 0);
    checkOutput("t5_txn_cnt", TXN_CNT, 0);
    checkOutput("t5_timeout_cnt", TIMEOUT_CNT, 0);
    do_reset();
    req_v = 4'b1010;
    tick();
    tick();
    checkOutput("t5_first_grant", GRANT, 4'b0010);
    run_idle();

    // Stale done level across init; requester drops its request during the wait.
    done_lvl = 1'b1;
    tick();
    tick();
    plan_q.push_back('{P + 3, P + 6, 1'b1, 1'b0});
    req_v = 4'b1000;
    tick();
    for (int k = 0; k < 50 && cyc < cur_c + P + 1; k++) tick();
    req_v = '0;
    for (int k = 0; k < 50 && cyc < cur_r; k++) tick();
    checkOutput("t6_req_done", REQ_DONE, 4'b1000);
    run_idle();

    // Randomized traffic.
    do_reset();
    rand_mode = 1;
    repeat (3000) tick();
    rand_mode = 0;
    run_idle();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
